// File: rtl/seg_scan_pkg.sv
// Shared constants and slot type for the four-digit multiplexed display scanner.
package seg_scan_pkg;

   localparam int          NUM_DIGITS = 4;
   localparam logic [3:0]  BLANK_CODE = 4'hF;
   localparam logic [3:0]  AN_OFF     = 4'b1111;

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2,
      SLOT3 = 2'd3
   } slot_e;

   function automatic logic [3:0] an_select(input slot_e s);
      return ~(4'b0001 << s);
   endfunction

   function automatic slot_e next_slot(input slot_e s);
      return slot_e'(2'(s + 2'd1));
   endfunction

endpackage

// File: rtl/seg_scan_mux_refresh_tick.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count of each period.
module refresh_tick #(
   parameter int DIV = 100000
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   output logic [$clog2(DIV)-1:0]   o_count,
   output logic                     o_wrap
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] r_count;
   logic          w_wrap;

   assign w_wrap  = (r_count == CW'(DIV - 1));
   assign o_count = r_count;
   assign o_wrap  = w_wrap;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)    r_count <= '0;
      else if (w_wrap) r_count <= '0;
      else             r_count <= r_count + 1'b1;
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit anode scanner with guard blanking, leading-zero blanking and
// frame-synchronous display updates so a digit never tears mid-frame.
module seg_scan_mux
   import seg_scan_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic        blank_lz,
   output logic [3:0]  bcd,
   output logic [3:0]  an,
   output logic        frame_start
);

   localparam int TW = $clog2(REFRESH_DIV);

   logic [TW-1:0] w_tick;
   logic          w_wrap;
   logic          w_boundary;
   logic          w_guard;
   logic          w_lz;
   logic          w_blank;
   logic [3:0]    w_nib;

   slot_e         r_idx;
   logic [15:0]   r_display;
   logic [15:0]   r_pending;
   logic          r_pend_valid;
   logic [3:0]    r_an;
   logic [3:0]    r_bcd;
   logic          r_frame_start;

   refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .o_count (w_tick),
      .o_wrap  (w_wrap)
   );

   assign w_boundary = w_wrap && (r_idx == SLOT3);
   assign w_guard    = (w_tick < TW'(GUARD));

   always_comb begin
      w_lz  = 1'b0;
      w_nib = r_display[3:0];
      unique case (r_idx)
         SLOT0: begin w_lz = 1'b0;                     w_nib = r_display[3:0];   end
         SLOT1: begin w_lz = (r_display[15:4]  == '0); w_nib = r_display[7:4];   end
         SLOT2: begin w_lz = (r_display[15:8]  == '0); w_nib = r_display[11:8];  end
         SLOT3: begin w_lz = (r_display[15:12] == '0); w_nib = r_display[15:12]; end
      endcase
   end

   assign w_blank = w_guard || (blank_lz && w_lz);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx <= SLOT0;
      end else if (w_wrap) begin
         r_idx <= next_slot(r_idx);
      end
   end

   // A load landing on the boundary itself bypasses the pending buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_display    <= '0;
         r_pending    <= '0;
         r_pend_valid <= 1'b0;
      end else if (w_boundary) begin
         if (load)              r_display <= digits_in;
         else if (r_pend_valid) r_display <= r_pending;
         r_pend_valid <= 1'b0;
      end else if (load) begin
         r_pending    <= digits_in;
         r_pend_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_an          <= AN_OFF;
         r_bcd         <= BLANK_CODE;
         r_frame_start <= 1'b0;
      end else begin
         r_an          <= w_blank ? AN_OFF     : an_select(r_idx);
         r_bcd         <= w_blank ? BLANK_CODE : w_nib;
         r_frame_start <= w_boundary;
      end
   end

   assign an          = r_an;
   assign bcd         = r_bcd;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised and directed bench for seg_scan_mux against a frame-level reference model.
module tb_seg_scan_mux;

   localparam int DIV   = 8;
   localparam int GRD   = 2;
   localparam int FRAME = DIV * 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] digits_in;
   logic        blank_lz;
   logic [3:0]  bcd;
   logic [3:0]  an;
   logic        frame_start;

   int unsigned vectors;
   int unsigned miscompares;

   // reference state: elapsed cycles since reset release plus frame data
   int          m_t;
   logic [15:0] m_disp;
   logic [15:0] m_pend;
   bit          m_pv;
   bit          cur_blz;
   bit          seen_one;
   logic [3:0]  obs_bcd [4];

   seg_scan_mux #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .digits_in   (digits_in),
      .blank_lz    (blank_lz),
      .bcd         (bcd),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic cycle(input bit rst, input bit ld, input logic [15:0] din);
      int         tick, slot;
      logic [3:0] ea, eb;
      bit         ef;
      tick = m_t % DIV;
      slot = (m_t / DIV) % 4;
      if (!rst) begin
         ea = 4'hF; eb = 4'hF; ef = 1'b0;
      end else begin
         ef = (slot == 3) && (tick == DIV - 1);
         if (tick < GRD || (slot > 0 && cur_blz && (m_disp >> (4 * slot)) == 16'h0)) begin
            ea = 4'hF; eb = 4'hF;
         end else begin
            ea = ~(4'b0001 << slot);
            eb = m_disp[4*slot +: 4];
         end
      end
      rst_n = rst; load = ld; digits_in = din; blank_lz = cur_blz;
      @(posedge clk); #1;
      vectors++;
      if (an !== ea) begin
         miscompares++;
         $display("FAIL an t=%0d slot=%0d tick=%0d got=%b exp=%b", m_t, slot, tick, an, ea);
      end
      vectors++;
      if (bcd !== eb) begin
         miscompares++;
         $display("FAIL bcd t=%0d slot=%0d tick=%0d got=%h exp=%h", m_t, slot, tick, bcd, eb);
      end
      vectors++;
      if (frame_start !== ef) begin
         miscompares++;
         $display("FAIL frame_start t=%0d got=%b exp=%b", m_t, frame_start, ef);
      end
      vectors++;
      if ($countones(~an) > 1) begin
         miscompares++;
         $display("FAIL an_onehot t=%0d got=%b exp=at most one low", m_t, an);
      end
      if (rst && tick == 4) obs_bcd[slot] = bcd;
      if (bcd === 4'h1) seen_one = 1'b1;
      if (!rst) begin
         m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
      end else begin
         if (slot == 3 && tick == DIV - 1) begin
            if (ld)        m_disp = din;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
         end else if (ld) begin
            m_pend = din; m_pv = 1'b1;
         end
         m_t++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0);
   endtask

   // advance until the next cycle to be applied sits at the given frame position
   task automatic run_to(input int pos);
      for (int i = 0; i < FRAME && (m_t % FRAME) != pos; i++) cycle(1'b1, 1'b0, 16'h0);
   endtask

   task automatic check_frame(input logic [15:0] exp, input string name);
      for (int s = 0; s < 4; s++) begin
         logic [3:0] e;
         e = exp[4*s +: 4];
         vectors++;
         if (obs_bcd[s] !== e) begin
            miscompares++;
            $display("FAIL %s slot%0d got=%h exp=%h", name, s, obs_bcd[s], e);
         end
      end
   endtask

   task automatic test_reset;
      cur_blz = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0);
      idle(DIV);
   endtask

   task automatic test_load_commit;
      run_to(DIV + 3);
      cycle(1'b1, 1'b1, 16'h1234);
      run_to(0);
      idle(FRAME);
      check_frame(16'h1234, "load_1234");
   endtask

   task automatic test_lz;
      cur_blz = 1'b1;
      run_to(DIV);
      cycle(1'b1, 1'b1, 16'h0050);
      run_to(0);
      idle(FRAME);
      check_frame(16'hFF50, "lz_0050");
      cycle(1'b1, 1'b1, 16'h0000);
      run_to(0);
      idle(FRAME);
      check_frame(16'hFFF0, "lz_0000");
      cur_blz = 1'b0;
   endtask

   task automatic test_back_to_back;
      cycle(1'b0, 1'b0, 16'h0);
      seen_one = 1'b0;
      idle(3);
      cycle(1'b1, 1'b1, 16'h1111);
      idle(4);
      cycle(1'b1, 1'b1, 16'h2222);
      run_to(0);
      idle(FRAME);
      check_frame(16'h2222, "last_wins");
      vectors++;
      if (seen_one) begin
         miscompares++;
         $display("FAIL no_1111 got=seen exp=never");
      end
   endtask

   task automatic test_boundary_load;
      run_to(FRAME - 1);
      cycle(1'b1, 1'b1, 16'h9876);
      idle(FRAME);
      check_frame(16'h9876, "boundary_9876");
   endtask

   task automatic test_reset_mid;
      run_to(2 * DIV + 1);
      cycle(1'b1, 1'b1, 16'hABCD);
      idle(2);
      cycle(1'b0, 1'b0, 16'h0);
      idle(2 * FRAME);
      check_frame(16'h0000, "reset_discard");
   endtask

   task automatic test_random;
      for (int i = 0; i < 1500; i++) begin
         bit          r, l;
         logic [15:0] d;
         r = ($urandom_range(0, 199) != 0);
         l = ($urandom_range(0, 9) == 0);
         d = 16'($urandom);
         if ($urandom_range(0, 63) == 0) cur_blz = ~cur_blz;
         if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
         cycle(r, l, d);
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
      cur_blz = 1'b0; seen_one = 1'b0;
      for (int s = 0; s < 4; s++) obs_bcd[s] = 4'hX;
      rst_n = 1'b0; load = 1'b0; digits_in = '0; blank_lz = 1'b0;
      test_reset();
      test_load_commit();
      test_lz();
      test_back_to_back();
      test_boundary_load();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
